line_pixel_writer: RTL and testbench

LINE_PIXEL_WRITER -- requirements
Module: line_pixel_writer

---
 rtl/line_pixel_writer.sv | 166 ++++++++++++++++
 tb/tb_line_pixel_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_pixel_writer.sv
// Line pixel writer: queues plotted pixels in a small FIFO and applies each one to a
// 1 bpp, 16-pixel-per-word framebuffer by read-modify-write; also runs whole-frame clears.
module line_pixel_writer #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        plot,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   input  logic        ink,
   input  logic        clear_start,
   output logic        mem_req,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy,
   output logic        overflow
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = 17;
   localparam logic [11:0] CLR_LAST = 12'hFFF;

   typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

   // FIFO entry layout: {x[7:0], y[7:0], ink}
   logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ENT_W-1:0] hold_q, hold_d;
   logic [11:0]      clr_cnt_q, clr_cnt_d;
   logic [11:0]      mem_addr_q, mem_addr_d;
   logic [15:0]      mem_wdata_q, mem_wdata_d;
   logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic             busy_q, busy_d, overflow_q, overflow_d;
   state_t           state_q, state_d;

   logic             fifo_full, fifo_empty, push, pop;
   logic [ENT_W-1:0] head;
   logic [15:0]      bit_mask;

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = (state_q == IDLE) && !clear_start && !fifo_empty;
   assign push       = plot && (!fifo_full || pop);
   assign head       = fifo_q[rd_ptr_q];
   assign bit_mask   = 16'h0001 << hold_q[12:9];

   // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_d = overflow_q || (plot && !push);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {x, y, ink};
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and clear counter
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               state_d   = CLR;
               clr_cnt_d = '0;
            end else if (!fifo_empty) begin
               state_d = RD;
            end
         end
         RD:  if (mem_ack) state_d = WR;
         WR:  if (mem_ack) state_d = IDLE;
         CLR: begin
            if (mem_ack) begin
               if (clr_cnt_q == CLR_LAST) state_d = IDLE;
               else                       clr_cnt_d = clr_cnt_q + 12'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request channel and holding register, all registered
   always_comb begin
      hold_d      = hold_q;
      mem_req_d   = (state_d != IDLE);
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = (state_d != IDLE) || (count_d != '0);
      case (state_q)
         IDLE: begin
            if (state_d == CLR) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
            end else if (pop) begin
               hold_d     = head;
               mem_we_d   = 1'b0;
               mem_addr_d = {head[8:1], head[16:13]};
            end
         end
         RD: begin
            mem_addr_d = {hold_q[8:1], hold_q[16:13]};
            if (mem_ack) begin
               mem_we_d    = 1'b1;
               mem_wdata_d = hold_q[0] ? (mem_rdata | bit_mask) : (mem_rdata & ~bit_mask);
            end
         end
         WR:  if (mem_ack) mem_we_d = 1'b0;
         CLR: begin
            if (mem_ack && state_d == CLR) mem_addr_d = clr_cnt_d;
            else if (mem_ack)              mem_we_d   = 1'b0;
         end
         default: mem_we_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         hold_q      <= '0;
         clr_cnt_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         hold_q      <= hold_d;
         clr_cnt_q   <= clr_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed bench for line_pixel_writer with a behavioural framebuffer of programmable ack latency.
module tb_line_pixel_writer;
   logic        clk, reset, plot, ink, clear_start;
   logic [7:0]  x, y;
   logic        mem_req, mem_we, mem_ack, busy, overflow;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   line_pixel_writer #(.FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .ink(ink),
      .clear_start(clear_start), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .busy(busy), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Framebuffer model: ack after lat extra cycles of continuous request
   logic [15:0] fb [4096];
   logic [11:0] wlog_addr [8192];
   logic [15:0] wlog_data [8192];
   logic [11:0] rlog_addr [256];
   int          wr_n = 0, rd_n = 0, wcnt = 0, lat = 0;
   logic        poke_en;
   logic [11:0] poke_addr;
   logic [15:0] poke_data;

   assign mem_ack   = mem_req && (wcnt == lat);
   assign mem_rdata = fb[mem_addr];

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) wcnt <= 0;
      else                              wcnt <= wcnt + 1;
      if (poke_en) begin
         fb[poke_addr] <= poke_data;
      end else if (mem_req && mem_ack) begin
         if (mem_we) begin
            fb[mem_addr]     <= mem_wdata;
            wlog_addr[wr_n]  <= mem_addr;
            wlog_data[wr_n]  <= mem_wdata;
            wr_n             <= wr_n + 1;
         end else begin
            rlog_addr[rd_n]  <= mem_addr;
            rd_n             <= rd_n + 1;
         end
      end
   end

   int n_checks = 0, n_errors = 0;
   int wbase, rbase, n;
   int burst_idx [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic plot_px(input logic [7:0] px, input logic [7:0] py, input logic pink);
      plot = 1'b1; x = px; y = py; ink = pink;
      tick();
      plot = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int k = 0;
      while (busy && k < max_cyc) begin
         tick();
         k++;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      reset = 1'b1; plot = 1'b0; ink = 1'b0; clear_start = 1'b0; x = '0; y = '0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;
      tick(); tick();
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;

      // Single pixel, zero-wait memory
      lat = 0;
      poke(12'h012, 16'h0000);
      wbase = wr_n; rbase = rd_n;
      plot_px(8'h23, 8'h01, 1'b1);
      check("t1_busy_c1", busy, 1);
      tick();
      check("t1_rd_req", mem_req, 1);
      check("t1_rd_we", mem_we, 0);
      check("t1_rd_addr", mem_addr, 12'h012);
      tick();
      check("t1_wr_req", mem_req, 1);
      check("t1_wr_we", mem_we, 1);
      check("t1_wr_addr", mem_addr, 12'h012);
      check("t1_wr_data", mem_wdata, 16'h0008);
      tick();
      check("t1_busy_c4", busy, 0);
      check("t1_req_drop", mem_req, 0);
      check("t1_fb", fb[12'h012], 16'h0008);
      check("t1_rd_log", rlog_addr[rbase], 12'h012);
      check("t1_nwr", wr_n - wbase, 1);

      // Erase the rightmost pixel of a full word
      poke(12'h0FF, 16'hFFFF);
      wbase = wr_n;
      plot_px(8'hFF, 8'h0F, 1'b0);
      wait_idle(20);
      check("t2_addr", wlog_addr[wbase], 12'h0FF);
      check("t2_data", wlog_data[wbase], 16'h7FFF);
      check("t2_fb", fb[12'h0FF], 16'h7FFF);

      // Burst of 20 plots into an 8-deep FIFO against a slow memory
      lat = 4;
      for (int i = 0; i < 20; i++) poke({8'(i), 4'h3}, 16'h0000);
      wbase = wr_n;
      for (int i = 0; i < 20; i++) begin
         plot_px(8'h35, 8'(i), 1'b1);
         if (i == 8) check("t3_ovf_at8", overflow, 0);
         if (i == 9) check("t3_ovf_at9", overflow, 1);
      end
      wait_idle(400);
      check("t3_nwr", wr_n - wbase, 10);
      for (int k = 0; k < 10; k++) begin
         check("t3_addr", wlog_addr[wbase + k], {8'(burst_idx[k]), 4'h3});
         check("t3_data", wlog_data[wbase + k], 16'h0020);
      end
      check("t3_ovf_sticky", overflow, 1);

      // Push and pop on a full FIFO in the same cycle
      reset = 1'b1; tick(); reset = 1'b0;
      check("t4_ovf_rst", overflow, 0);
      for (int i = 0; i < 11; i++) poke({8'(8'h80 + i), 4'h3}, 16'h0000);
      wbase = wr_n;
      for (int i = 0; i < 9; i++) plot_px(8'h35, 8'(8'h80 + i), 1'b1);
      check("t4_ovf_full", overflow, 0);
      n = 0;
      while (mem_req && n < 30) begin tick(); n++; end
      check("t4_req_low_to", mem_req, 0);
      plot_px(8'h35, 8'h89, 1'b1);
      check("t4_ovf_pushpop", overflow, 0);
      plot_px(8'h35, 8'h8A, 1'b1);
      check("t4_ovf_drop", overflow, 1);
      wait_idle(400);
      check("t4_nwr", wr_n - wbase, 10);
      check("t4_last_addr", wlog_addr[wbase + 9], 12'h893);
      check("t4_first_addr", wlog_addr[wbase], 12'h803);

      // Reset in WR before the ack, with plot and clear_start also high
      lat = 10;
      poke(12'hC03, 16'h0000);
      wbase = wr_n;
      plot_px(8'h35, 8'hC0, 1'b1);
      n = 0;
      while (!mem_we && n < 40) begin tick(); n++; end
      check("t5_in_wr", mem_we, 1);
      reset = 1'b1; plot = 1'b1; clear_start = 1'b1;
      tick();
      reset = 1'b0; plot = 1'b0; clear_start = 1'b0;
      check("t5_req", mem_req, 0);
      check("t5_busy", busy, 0);
      check("t5_ovf", overflow, 0);
      check("t5_addr", mem_addr, 0);
      tick(); tick(); tick();
      check("t5_req_later", mem_req, 0);
      check("t5_busy_later", busy, 0);
      check("t5_nwr", wr_n - wbase, 0);

      // Clear takes priority over a queued pixel; plots during clear drawn afterwards
      lat = 0;
      poke(12'h000, 16'hABCD);
      poke(12'h002, 16'h1234);
      wbase = wr_n;
      plot_px(8'h00, 8'h00, 1'b1);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check("t6_clr_req", mem_req, 1);
      check("t6_clr_we", mem_we, 1);
      check("t6_clr_addr", mem_addr, 0);
      check("t6_clr_data", mem_wdata, 0);
      plot_px(8'h21, 8'h00, 1'b1);
      tick(); tick();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check("t6_busy_mid", busy, 1);
      wait_idle(6000);
      check("t6_nwr", wr_n - wbase, 4098);
      n = 0;
      for (int k = 0; k < 4096; k++) begin
         if (wlog_addr[wbase + k] !== 12'(k) || wlog_data[wbase + k] !== 16'h0000) n++;
      end
      check("t6_clr_seq_bad", n, 0);
      check("t6_px0_addr", wlog_addr[wbase + 4096], 12'h000);
      check("t6_px0_data", wlog_data[wbase + 4096], 16'h0001);
      check("t6_px1_addr", wlog_addr[wbase + 4097], 12'h002);
      check("t6_px1_data", wlog_data[wbase + 4097], 16'h0002);
      check("t6_fb0", fb[12'h000], 16'h0001);
      check("t6_fb_last", fb[12'hFFF], 16'h0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
